// File: rtl/alu_pkg.sv
// Shared widths, FSM states and opcode constants for the two-requester ALU arbiter.
package alu_pkg;

    localparam int OPERAND_W = 4;
    localparam int RESULT_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_A_INC  = 3'd0;
    localparam logic [2:0] OP_A_DEC  = 3'd1;
    localparam logic [2:0] OP_A_SHL1 = 3'd2;
    localparam logic [2:0] OP_B_INC  = 3'd3;
    localparam logic [2:0] OP_B_DEC  = 3'd4;
    localparam logic [2:0] OP_B_SHL1 = 3'd5;
    localparam logic [2:0] OP_ADD    = 3'd6;
    localparam logic [2:0] OP_A_SHL2 = 3'd7;

    localparam logic [2:0] LOP_NOT_A = 3'd0;
    localparam logic [2:0] LOP_NOT_B = 3'd1;
    localparam logic [2:0] LOP_AND   = 3'd2;
    localparam logic [2:0] LOP_OR    = 3'd3;
    localparam logic [2:0] LOP_XOR   = 3'd4;
    localparam logic [2:0] LOP_XNOR  = 3'd5;
    localparam logic [2:0] LOP_NAND  = 3'd6;
    localparam logic [2:0] LOP_NOR   = 3'd7;

    function automatic logic [RESULT_W-1:0] sext(input logic [OPERAND_W-1:0] v);
        return {{(RESULT_W-OPERAND_W){v[OPERAND_W-1]}}, v};
    endfunction

    // A 6-bit result fits the signed 4-bit range when its top three bits agree.
    function automatic logic fits_operand(input logic [RESULT_W-1:0] r);
        return (r[RESULT_W-1:OPERAND_W-1] == 3'b000) || (r[RESULT_W-1:OPERAND_W-1] == 3'b111);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational shared ALU: signed arithmetic with overflow flag, or zero-extended bitwise logic.
module alu_core
    import alu_pkg::*;
(
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    input  logic [3:0]           sel,
    output logic [RESULT_W-1:0]  z,
    output logic                 ovf
);

    logic [RESULT_W-1:0]  ae_s;
    logic [RESULT_W-1:0]  be_s;
    logic [RESULT_W-1:0]  arith_s;
    logic [OPERAND_W-1:0] logic_s;

    // Opcode decode and result select
    always_comb begin
        ae_s    = sext(a);
        be_s    = sext(b);
        arith_s = 6'd0;
        logic_s = 4'd0;
        case (sel[2:0])
            OP_A_INC:  arith_s = ae_s + 6'd1;
            OP_A_DEC:  arith_s = ae_s - 6'd1;
            OP_A_SHL1: arith_s = ae_s << 1;
            OP_B_INC:  arith_s = be_s + 6'd1;
            OP_B_DEC:  arith_s = be_s - 6'd1;
            OP_B_SHL1: arith_s = be_s << 1;
            OP_ADD:    arith_s = ae_s + be_s;
            OP_A_SHL2: arith_s = ae_s << 2;
            default:   arith_s = 6'd0;
        endcase
        case (sel[2:0])
            LOP_NOT_A: logic_s = ~a;
            LOP_NOT_B: logic_s = ~b;
            LOP_AND:   logic_s = a & b;
            LOP_OR:    logic_s = a | b;
            LOP_XOR:   logic_s = a ^ b;
            LOP_XNOR:  logic_s = ~(a ^ b);
            LOP_NAND:  logic_s = ~(a & b);
            LOP_NOR:   logic_s = ~(a | b);
            default:   logic_s = 4'd0;
        endcase
        if (sel[3]) begin
            z   = {2'b00, logic_s};
            ovf = 1'b0;
        end else begin
            z   = arith_s;
            ovf = ~fits_operand(arith_s);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one operation in flight at a time.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int PRIO_INIT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [OPERAND_W-1:0] req0_a,
    input  logic [OPERAND_W-1:0] req0_b,
    input  logic [3:0]           req0_sel,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [OPERAND_W-1:0] req1_a,
    input  logic [OPERAND_W-1:0] req1_b,
    input  logic [3:0]           req1_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [RESULT_W-1:0]  rsp_z,
    output logic                 rsp_ovf
);

    localparam logic PRIO_RST = (PRIO_INIT != 0) ? 1'b1 : 1'b0;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 prio_r;
    logic [OPERAND_W-1:0] a_r;
    logic [OPERAND_W-1:0] b_r;
    logic [3:0]           sel_r;
    logic                 id_r;
    logic                 rsp_valid_r;
    logic                 rsp_id_r;
    logic [RESULT_W-1:0]  rsp_z_r;
    logic                 rsp_ovf_r;
    logic                 grant_id_s;
    logic                 accept_s;
    logic                 rsp_done_s;
    logic [RESULT_W-1:0]  alu_z_s;
    logic                 alu_ovf_s;

    alu_core u_alu (
        .a   (a_r),
        .b   (b_r),
        .sel (sel_r),
        .z   (alu_z_s),
        .ovf (alu_ovf_s)
    );

    // Grant selection; a lone requester wins, a tie goes to the priority holder
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_id_s = prio_r;
        end else if (req1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
        accept_s   = (state_r == ST_IDLE) && (req0_valid || req1_valid) && !reset;
        req0_ready = accept_s && (grant_id_s == 1'b0);
        req1_ready = accept_s && (grant_id_s == 1'b1);
        rsp_done_s = (state_r == ST_RESP) && rsp_ready;
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, priority rotation and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_r      <= PRIO_RST;
            a_r         <= 4'd0;
            b_r         <= 4'd0;
            sel_r       <= 4'd0;
            id_r        <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_z_r     <= 6'd0;
            rsp_ovf_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                a_r    <= grant_id_s ? req1_a : req0_a;
                b_r    <= grant_id_s ? req1_b : req0_b;
                sel_r  <= grant_id_s ? req1_sel : req0_sel;
                id_r   <= grant_id_s;
                prio_r <= ~grant_id_s;
            end
            if (state_r == ST_EXEC) begin
                rsp_valid_r <= 1'b1;
                rsp_id_r    <= id_r;
                rsp_z_r     <= alu_z_s;
                rsp_ovf_r   <= alu_ovf_s;
            end else if (rsp_done_s) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_z     = rsp_z_r;
    assign rsp_ovf   = rsp_ovf_r;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, default 0, requester index (0 or 1) holding round-robin priority after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  operation of requester n accepted this edge when valid&&ready.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  4 each  signed operands.
REQ-007 req0_sel / req1_sel  input  4 each  bit3=0 arithmetic, bit3=1 logic; bits2:0 opcode.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result when rsp_valid&&rsp_ready.
REQ-010 rsp_id  output  1  requester index owning the result.
REQ-011 rsp_z  output  6  signed result.
REQ-012 rsp_ovf  output  1  arithmetic result outside signed 4-bit range (-8..7); always 0 for logic ops.

Function
REQ-013 Block SHALL share one ALU between two requesters, one operation outstanding at a time.
REQ-014 FSM states SHALL be IDLE, EXEC, RESP.
REQ-015 IDLE: if any valid, grant per REQ-019, assert only that requester's ready combinationally, capture a/b/sel/id on the edge, go to EXEC; else stay.
REQ-016 EXEC: register ALU result, ovf and id into response registers; go to RESP (exactly one cycle).
REQ-017 RESP: rsp_valid=1; hold rsp_id/rsp_z/rsp_ovf stable until rsp_valid&&rsp_ready; then go to IDLE.
REQ-018 req_ready SHALL be 0 in EXEC and RESP; latency accept-edge to rsp_valid = 2 edges; minimum issue interval 3 cycles.
REQ-019 Arbitration: single valid requester wins; both valid -> priority holder wins; after each grant priority moves to the other requester.
REQ-020 Requester may drop valid before grant without penalty; priority SHALL NOT change without a grant.
REQ-021 Arithmetic ops (sel3=0), operands sign-extended to 6 bits: 000 a+1, 001 a-1, 010 a<<1, 011 b+1, 100 b-1, 101 b<<1, 110 a+b, 111 a<<2.
REQ-022 Logic ops (sel3=1), 4-bit result zero-extended to 6 bits: 000 ~a, 001 ~b, 010 a&b, 011 a|b, 100 a^b, 101 ~(a^b), 110 ~(a&b), 111 ~(a|b).
REQ-023 No result SHALL be lost or duplicated; each accepted operation produces exactly one response.

Reset
REQ-024 reset asserted SHALL immediately force: state IDLE, rsp_valid 0, rsp_id 0, rsp_z 0, rsp_ovf 0, captured operands 0, priority PRIO_INIT.
REQ-025 reset during EXEC or RESP SHALL discard the in-flight operation; no response issued after deassertion.
REQ-026 req_ready SHALL be 0 while reset is asserted.

Structure
REQ-027 Shared package alu_pkg SHALL hold opcode constants, state enum, and widths (operand 4, result 6).
REQ-028 Combinational ALU SHALL be a sub-module alu_core (a, b, sel -> z, ovf); arbiter/FSM in alu_arbiter.

Verification
REQ-029 req0 a=7 b=7 sel=0110 alone -> accept edge N, rsp_valid at N+2, rsp_z=001110 (14), rsp_ovf=1, rsp_id=0.
REQ-030 req1 a=-8 sel=0111 -> rsp_z=100000 (-32), rsp_ovf=1, rsp_id=1.
REQ-031 req0 a=0101 b=0011 sel=1100 -> rsp_z=000110, rsp_ovf=0.
REQ-032 Both valid continuously, PRIO_INIT=0, rsp_ready=1 -> grants alternate 0,1,0,1; responses in order.
REQ-033 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_z stable, both req_ready 0, no new grant; release -> IDLE next edge.
REQ-034 reset pulsed in EXEC -> outputs zero at once; after release no response appears; next grant goes to PRIO_INIT.
